// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//
// Purpose: time-multiplexes one external pipelined multiplier (DATA_W x COEF_W,
// latency MUL_LAT ce-enabled cycles) across every tap of an NTAPS-tap FIR.
// Holds the sample delay line and the coefficient table. Issues one tap product
// per cycle, accumulates the returned products, and presents one filtered
// output per accepted input sample.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_data/valid/ready  input sample stream (ready only while idle)
//   out_data/valid/ready filtered output, held until accepted
//   coef_we/addr/data    coefficient table write port (honoured only while idle)
//   cfg_err              one-cycle pulse when a coefficient write is dropped
//   mul_ce/a/b, mul_p    shared multiplier enable, operands and low product bits
module fir_mac_sequencer #(
   parameter int NTAPS   = 16,
   parameter int DATA_W  = 32,
   parameter int COEF_W  = 10,
   parameter int MUL_LAT = 1,
   parameter int ACC_W   = 40,
   localparam int AW     = $clog2(NTAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     cfg_err,
   output logic                     mul_ce,
   output logic signed [DATA_W-1:0] mul_a,
   output logic signed [COEF_W-1:0] mul_b,
   input  logic signed [DATA_W-1:0] mul_p
);

   // One counter serves both the tap index in MAC and the drain count.
   localparam int CNT_W = $clog2(NTAPS + MUL_LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [AW-1:0]             wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]             tap_idx, rd_ptr;
   logic signed [DATA_W-1:0]  delay_mem [NTAPS];
   logic signed [COEF_W-1:0]  coef_mem  [NTAPS];
   logic [NTAPS-1:0]          delay_wr, coef_wr;
   logic [MUL_LAT-1:0]        vld_reg;
   logic signed [ACC_W-1:0]   acc_reg, acc_next, out_data_reg;
   logic signed [ACC_W-1:0]   mul_p_sext;
   logic                      cfg_err_reg;
   logic                      accept, issue, coef_ok;

   // ------------------------------------------------------------------
   // Handshake and address arithmetic
   // ------------------------------------------------------------------
   assign in_ready    = (state_reg == IDLE) && !reset;
   assign accept      = in_valid && in_ready;
   assign wr_ptr_next = wr_ptr_reg + 1'b1;
   assign tap_idx     = cnt_reg[AW-1:0];
   // Tap 0 is the newest sample; older taps walk backwards around the ring.
   assign rd_ptr      = wr_ptr_reg - tap_idx;
   assign issue       = (state_reg == MAC);
   assign coef_ok     = (state_reg == IDLE);
   assign mul_p_sext  = ACC_W'(mul_p);

   genvar gi;
   generate
      for (gi = 0; gi < NTAPS; gi++) begin : g_wr
         assign delay_wr[gi] = accept && (wr_ptr_next == AW'(gi));
         assign coef_wr[gi]  = coef_we && coef_ok && (coef_addr == AW'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // FSM: next state, counter and multiplier-side outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mul_ce     = 1'b0;
      mul_a      = '0;
      mul_b      = '0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = MAC;
               cnt_next   = '0;
            end
         end
         MAC: begin
            mul_ce = 1'b1;
            mul_a  = delay_mem[rd_ptr];
            mul_b  = coef_mem[tap_idx];
            if (cnt_reg == CNT_W'(NTAPS - 1)) begin
               state_next = DRAIN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DRAIN: begin
            // Keep the multiplier clocked with zero operands so the last
            // real products reach mul_p.
            mul_ce = 1'b1;
            if (cnt_reg == CNT_W'(MUL_LAT - 1)) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Accumulator: the tail of the issue-valid pipe marks a real product
   // on mul_p this cycle. Wraps modulo 2^ACC_W.
   // ------------------------------------------------------------------
   always_comb begin
      acc_next = acc_reg;
      if (accept) begin
         acc_next = '0;
      end else if (vld_reg[MUL_LAT-1]) begin
         acc_next = acc_reg + mul_p_sext;
      end
   end

   // ------------------------------------------------------------------
   // Control and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         wr_ptr_reg   <= '0;
         acc_reg      <= '0;
         out_data_reg <= '0;
         cfg_err_reg  <= 1'b0;
         vld_reg      <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         cfg_err_reg <= coef_we && !coef_ok;
         if (accept) begin
            wr_ptr_reg <= wr_ptr_next;
         end
         // The final product lands on the same edge that enters DONE, so the
         // output register takes the already-updated sum.
         if (state_reg == DRAIN && state_next == DONE) begin
            out_data_reg <= acc_next;
         end
         // The valid pipe advances only when the multiplier does.
         if (mul_ce) begin
            vld_reg[0] <= issue;
            for (int i = 1; i < MUL_LAT; i++) begin
               vld_reg[i] <= vld_reg[i-1];
            end
         end
      end
   end

   // Delay line and coefficient table; cleared by reset, so kept in registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            delay_mem[i] <= '0;
            coef_mem[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NTAPS; i++) begin
            if (delay_wr[i]) begin
               delay_mem[i] <= in_data;
            end
            if (coef_wr[i]) begin
               coef_mem[i] <= coef_data;
            end
         end
      end
   end

   assign out_data = out_data_reg;
   assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

   localparam int NTAPS   = 4;
   localparam int DATA_W  = 32;
   localparam int COEF_W  = 10;
   localparam int MUL_LAT = 1;
   localparam int ACC_W   = 40;
   localparam int AW      = 2;
   localparam int LAT     = NTAPS + MUL_LAT + 1;
   localparam int PERIOD  = NTAPS + MUL_LAT + 2;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic signed [DATA_W-1:0] in_data = '0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic signed [ACC_W-1:0]  out_data;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic                     coef_we = 1'b0;
   logic [AW-1:0]            coef_addr = '0;
   logic signed [COEF_W-1:0] coef_data = '0;
   logic                     cfg_err;
   logic                     mul_ce;
   logic signed [DATA_W-1:0] mul_a;
   logic signed [COEF_W-1:0] mul_b;
   logic signed [DATA_W-1:0] mul_p;

   int checks = 0;
   int failures = 0;

   fir_mac_sequencer #(
      .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
      .MUL_LAT(MUL_LAT), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .cfg_err(cfg_err),
      .mul_ce(mul_ce), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
   );

   always #5 clk = ~clk;

   // Low DATA_W bits of the full signed product.
   function automatic logic signed [DATA_W-1:0] mul_lo(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [COEF_W-1:0] b);
      logic signed [63:0] aa, bb, p;
      aa = a;
      bb = b;
      p  = aa * bb;
      return p[DATA_W-1:0];
   endfunction

   // Shared multiplier: pipeline of MUL_LAT stages, advancing only on mul_ce.
   logic signed [DATA_W-1:0] mpipe [MUL_LAT];
   initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
   always @(posedge clk) begin
      if (mul_ce === 1'b1) begin
         mpipe[0] <= mul_lo(mul_a, mul_b);
         for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   assign mul_p = mpipe[MUL_LAT-1];

   // Reference model: newest-first sample history and coefficient table.
   logic signed [DATA_W-1:0] m_hist [NTAPS];
   logic signed [COEF_W-1:0] m_coef [NTAPS];

   function automatic void model_clear();
      for (int k = 0; k < NTAPS; k++) begin
         m_hist[k] = '0;
         m_coef[k] = '0;
      end
   endfunction

   function automatic void model_push(input logic signed [DATA_W-1:0] x);
      for (int k = NTAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = x;
   endfunction

   function automatic logic signed [ACC_W-1:0] model_out();
      logic signed [ACC_W-1:0] s;
      logic [DATA_W-1:0] lo;
      s = '0;
      for (int k = 0; k < NTAPS; k++) begin
         lo = mul_lo(m_hist[k], m_coef[k]);
         s  = s + {{(ACC_W-DATA_W){lo[DATA_W-1]}}, lo};
      end
      return s;
   endfunction

   task automatic write_coef(input logic [AW-1:0] a, input logic signed [COEF_W-1:0] d);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
      m_coef[a] = d;
      checks++;
      if (cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL cfg_err_idle got=%0b want=0", cfg_err);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL wait_idle in_ready got=%0b want=1", in_ready);
      end
   endtask

   // One sample through the block, optionally with a same-cycle coef write and
   // hold cycles of backpressure. Checks latency, operands, data and handshake.
   task automatic run_sample(input logic signed [DATA_W-1:0] x, input bit we,
                             input logic [AW-1:0] a, input logic signed [COEF_W-1:0] d,
                             input int hold, output logic signed [ACC_W-1:0] got);
      logic signed [ACC_W-1:0] exp;
      int first, ce_n, n;
      bit op_bad;
      wait_idle();
      in_data = x; in_valid = 1'b1;
      coef_we = we; coef_addr = a; coef_data = d;
      if (we) m_coef[a] = d;
      model_push(x);
      exp = model_out();
      @(negedge clk);
      in_valid = 1'b0; coef_we = 1'b0;
      first = 0; ce_n = 0; op_bad = 1'b0;
      for (n = 1; n <= 40; n++) begin
         if (mul_ce === 1'b1) ce_n++;
         if (n <= NTAPS) begin
            if (mul_a !== m_hist[n-1] || mul_b !== m_coef[n-1]) op_bad = 1'b1;
         end else if (n <= NTAPS + MUL_LAT) begin
            if (mul_a !== '0 || mul_b !== '0) op_bad = 1'b1;
         end
         if (out_valid === 1'b1) begin first = n; break; end
         @(negedge clk);
      end
      got = out_data;
      checks++;
      if (first != LAT) begin
         failures++;
         $display("FAIL latency got=%0d want=%0d", first, LAT);
      end
      checks++;
      if (ce_n != NTAPS + MUL_LAT) begin
         failures++;
         $display("FAIL mul_ce_cycles got=%0d want=%0d", ce_n, NTAPS + MUL_LAT);
      end
      checks++;
      if (op_bad) begin
         failures++;
         $display("FAIL operands got=bad want=tap_order");
      end
      checks++;
      if (out_data !== exp || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL out_data got=%0h want=%0h in_ready=%0b", out_data, exp, in_ready);
      end
      $display("sample x=%0h out=%0h exp=%0h", x, out_data, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure cyc=%0d got v=%0b d=%0h r=%0b want v=1 d=%0h r=0",
                     h, out_valid, out_data, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL handshake got v=%0b r=%0b want v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || mul_ce !== 1'b0 || cfg_err !== 1'b0 ||
          mul_a !== '0 || mul_b !== '0 || out_data !== '0) begin
         failures++;
         $display("FAIL reset_outputs got r=%0b v=%0b ce=%0b e=%0b a=%0h b=%0h d=%0h want all 0",
                  in_ready, out_valid, mul_ce, cfg_err, mul_a, mul_b, out_data);
      end
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_ce !== 1'b0) begin
         failures++;
         $display("FAIL after_reset got r=%0b v=%0b ce=%0b want r=1 v=0 ce=0",
                  in_ready, out_valid, mul_ce);
      end
   endtask

   task automatic test_impulse();
      logic signed [ACC_W-1:0] got;
      logic signed [ACC_W-1:0] want;
      for (int k = 0; k < NTAPS; k++) write_coef(AW'(k), COEF_W'(k + 1));
      for (int j = 0; j < NTAPS; j++) begin
         run_sample((j == 0) ? 32'sd1 : 32'sd0, 1'b0, '0, '0, 0, got);
         want = ACC_W'(j + 1);
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL impulse j=%0d got=%0h want=%0h", j, got, want);
         end
      end
   endtask

   task automatic test_wrap();
      logic signed [ACC_W-1:0] got;
      logic signed [ACC_W-1:0] want;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
      write_coef(2'd0, -10'sd512);
      run_sample(32'sh8000_0000, 1'b0, '0, '0, 0, got);
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL wrap_min got=%0h want=0", got);
      end
      // Same-cycle coefficient write must be used by this sample.
      run_sample(32'sh7FFF_FFFF, 1'b1, 2'd0, 10'sd511, 0, got);
      want = 40'sh00_7FFF_FE01;
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL wrap_max got=%0h want=%0h", got, want);
      end
   endtask

   task automatic test_backpressure();
      logic signed [ACC_W-1:0] got;
      run_sample($urandom, 1'b0, '0, '0, 10, got);
   endtask

   task automatic test_busy_write();
      logic signed [ACC_W-1:0] exp, got;
      logic [AW-1:0] a;
      int n;
      for (int k = 0; k < NTAPS; k++) write_coef(AW'(k), COEF_W'($urandom));
      wait_idle();
      in_data = $urandom; in_valid = 1'b1;
      model_push(in_data);
      exp = model_out();
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      a = AW'($urandom);
      coef_we = 1'b1; coef_addr = a; coef_data = m_coef[a] ^ 10'sh155;
      @(negedge clk);
      coef_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin
         failures++;
         $display("FAIL cfg_err_pulse got=%0b want=1", cfg_err);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL cfg_err_width got=%0b want=0", cfg_err);
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
         failures++;
         $display("FAIL busy_inflight got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      // Next sample must still see the old coefficient.
      run_sample($urandom, 1'b0, '0, '0, 0, got);
   endtask

   task automatic test_reset_in_mac();
      logic signed [ACC_W-1:0] got;
      bit seen;
      wait_idle();
      in_data = $urandom; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (mul_ce !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin
         failures++;
         $display("FAIL reset_in_mac got ce=%0b r=%0b d=%0h want 0 0 0", mul_ce, in_ready, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL aborted_output got=1 want=0");
      end
      for (int j = 0; j < NTAPS; j++) begin
         run_sample((j == 0) ? 32'sd1 : 32'sd0, 1'b0, '0, '0, 0, got);
         checks++;
         if (got !== '0) begin
            failures++;
            $display("FAIL zero_coef j=%0d got=%0h want=0", j, got);
         end
      end
   endtask

   task automatic test_random();
      logic signed [ACC_W-1:0] got;
      for (int k = 0; k < NTAPS; k++) write_coef(AW'(k), COEF_W'($urandom));
      for (int j = 0; j < 8; j++) begin
         run_sample($urandom, 1'($urandom_range(0, 1)), AW'($urandom), COEF_W'($urandom),
                    $urandom_range(0, 3), got);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [ACC_W-1:0] q[$];
      logic signed [ACC_W-1:0] exp;
      int sent, recv, last_c;
      for (int k = 0; k < NTAPS; k++) write_coef(AW'(k), COEF_W'($urandom));
      out_ready = 1'b1;
      sent = 0; recv = 0; last_c = 0;
      for (int c = 0; c < 300 && recv < 6; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra got=%0h want=none", out_data);
            end else begin
               exp = q.pop_front();
               if (out_data !== exp) begin
                  failures++;
                  $display("FAIL b2b_data got=%0h want=%0h", out_data, exp);
               end
               $display("b2b out=%0h exp=%0h", out_data, exp);
            end
            recv++;
         end
         if (in_ready === 1'b1 && sent < 6) begin
            in_data = $urandom; in_valid = 1'b1;
            model_push(in_data);
            q.push_back(model_out());
            if (sent > 0) begin
               checks++;
               if (c - last_c != PERIOD) begin
                  failures++;
                  $display("FAIL b2b_period got=%0d want=%0d", c - last_c, PERIOD);
               end
            end
            last_c = c;
            sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (recv != 6) begin
         failures++;
         $display("FAIL b2b_count got=%0d want=6", recv);
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_impulse();
      test_wrap();
      test_backpressure();
      test_busy_write();
      test_reset_in_mac();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
